// File: rtl/vx_acc_csr_bridge.sv
// vx_acc_csr_bridge
// Bridges 32-bit CSR command writes onto a single-outstanding accelerator
// command/response handshake. The CSR readback shows either a status word
// or the last accelerator result.
//
// Optional feature: define VX_ACC_TIMEOUT_EN to enable a WAIT-state response
// timeout of TIMEOUT_CYCLES cycles. Without it, WAIT lasts until a response
// arrives and timeout_err reads as 0.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   acc_write_en      : command-word write strobe (one pulse per write)
//   acc_write_out     : command word, [31:30] op, [29:0] payload
//   acc_read_in       : readback (sel=0 status, sel=1 result)
//   cmd_valid/ready   : accelerator command handshake, cmd_data payload
//   rsp_valid/ready   : accelerator response handshake, rsp_data result
//   busy              : FSM not IDLE
//
// State | meaning
// IDLE  | no command outstanding
// ISSUE | cmd_valid held until cmd_ready
// WAIT  | rsp_ready held until rsp_valid (or timeout when enabled)
module vx_acc_csr_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_write_en,
  input  logic [31:0] acc_write_out,
  output logic [31:0] acc_read_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic [31:0] result_q, result_d;
  logic        sel_q, sel_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;
  logic        timeout_err;
  logic        expire;

  logic [1:0] op;
  logic       wr_launch, wr_sel_status, wr_sel_result, wr_clear;
  logic       launch_idle, rsp_hs;

  assign op            = acc_write_out[31:30];
  assign wr_launch     = acc_write_en && (op == 2'b00);
  assign wr_sel_status = acc_write_en && (op == 2'b01);
  assign wr_sel_result = acc_write_en && (op == 2'b10);
  assign wr_clear      = acc_write_en && (op == 2'b11);
  assign launch_idle   = wr_launch && (state_q == S_IDLE);
  assign rsp_hs        = (state_q == S_WAIT) && rsp_valid;

`ifdef VX_ACC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Counter is held at zero outside WAIT, so it is already clear on WAIT entry.
  // A response on the expiry cycle takes precedence over the timeout.
  assign expire = (state_q == S_WAIT) && !rsp_valid &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = ((state_q == S_WAIT) && !rsp_valid) ? cnt_q + 1'b1 : '0;

  always_comb begin
    timeout_err_d = timeout_err_q;
    if (launch_idle || wr_clear) timeout_err_d = 1'b0;
    if (expire)                  timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign expire      = 1'b0;
  // Constant 0 for any legal parameter value; the parameter stays part of
  // the interface in both builds.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wr_launch)          state_d = S_ISSUE;
      S_ISSUE: if (cmd_ready)          state_d = S_WAIT;
      S_WAIT:  if (rsp_valid || expire) state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so an async reset drops
  // them immediately.
  always_comb begin
    cmd_valid = (state_q == S_ISSUE);
    rsp_ready = (state_q == S_WAIT);
    busy      = (state_q != S_IDLE);
  end

  // Datapath and sticky status; a response beats a simultaneous CLEAR on done.
  always_comb begin
    cmd_data_d = cmd_data_q;
    result_d   = result_q;
    sel_d      = sel_q;
    done_d     = done_q;
    dropped_d  = dropped_q;
    if (launch_idle)                         cmd_data_d = {2'b00, acc_write_out[29:0]};
    if (rsp_hs)                              result_d   = rsp_data;
    if (wr_sel_status)                       sel_d      = 1'b0;
    if (wr_sel_result)                       sel_d      = 1'b1;
    if (launch_idle || wr_clear)             done_d     = 1'b0;
    if (rsp_hs)                              done_d     = 1'b1;
    if (wr_clear)                            dropped_d  = 1'b0;
    if (wr_launch && (state_q != S_IDLE))    dropped_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_data_q <= '0;
      result_q   <= '0;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      cmd_data_q <= cmd_data_d;
      result_q   <= result_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

  assign cmd_data    = cmd_data_q;
  assign acc_read_in = sel_q ? result_q
                             : {28'b0, dropped_q, timeout_err, done_q, busy};

endmodule

// File: tb/tb_vx_acc_csr_bridge.sv
// Testbench for vx_acc_csr_bridge. Expected command words are queued when a
// LAUNCH is written and popped when the DUT completes a command handshake.
module tb_vx_acc_csr_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_write_en;
  logic [31:0] acc_write_out;
  logic [31:0] acc_read_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] cmd_q[$];

  vx_acc_csr_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .acc_write_en(acc_write_en), .acc_write_out(acc_write_out),
    .acc_read_in(acc_read_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] w);
    acc_write_en  = 1'b1;
    acc_write_out = w;
    tick();
    acc_write_en  = 1'b0;
  endtask

  task automatic launch(input logic [31:0] w);
    cmd_q.push_back({2'b00, w[29:0]});
    wr(w);
  endtask

  task automatic respond(input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  // Command scoreboard: every completed handshake must match a queued LAUNCH.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      chk("cmdq_nonempty", {31'b0, cmd_q.size() != 0}, 32'd1);
      if (cmd_q.size() != 0) chk("cmd_data", cmd_data, cmd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; acc_write_en = 1'b0; acc_write_out = '0;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    chk("rst_read", acc_read_in, 32'h0);
    reset = 1'b0;
    tick();

    // Basic launch / response / result readback
    launch(32'h0000_0005);
    chk("issue_valid", {31'b0, cmd_valid}, 32'd1);
    chk("issue_data", cmd_data, 32'h0000_0005);
    chk("issue_status", acc_read_in, 32'h1);
    tick();
    chk("wait_valid_low", {31'b0, cmd_valid}, 32'd0);
    chk("wait_rsp_ready", {31'b0, rsp_ready}, 32'd1);
    respond(32'hDEAD_BEEF);
    chk("done_status", acc_read_in, 32'h2);
    chk("done_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    wr(32'h8000_0000);
    chk("result_read", acc_read_in, 32'hDEAD_BEEF);
    wr(32'h4000_0000);

    // Backpressure on cmd_ready
    cmd_ready = 1'b0;
    launch(32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, cmd_valid}, 32'd1);
      chk("bp_data", cmd_data, 32'h0000_1234);
      chk("bp_status", acc_read_in, 32'h1);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    respond(32'h1111_2222);
    chk("bp_done", acc_read_in, 32'h2);

    // LAUNCH during WAIT is dropped
    launch(32'h0000_0001);
    tick();
    wr(32'h0000_0002);
    chk("drop_status", acc_read_in, 32'h9);
    respond(32'hCAFE_0001);
    chk("drop_done", acc_read_in, 32'hA);
    wr(32'h8000_0000);
    chk("drop_result", acc_read_in, 32'hCAFE_0001);
    wr(32'h4000_0000);
    wr(32'hC000_0000);
    chk("clear_status", acc_read_in, 32'h0);

    // CLEAR coinciding with the response handshake
    launch(32'h0000_0003);
    tick();
    acc_write_en = 1'b1; acc_write_out = 32'hC000_0000;
    respond(32'h5555_AAAA);
    acc_write_en = 1'b0;
    chk("clr_rsp_status", acc_read_in, 32'h2);
    wr(32'h8000_0000);
    wr(32'hC000_0000);
    chk("clr_keeps_sel", acc_read_in, 32'h5555_AAAA);

    // Response outside WAIT is ignored
    respond(32'h0BAD_0BAD);
    chk("idle_rsp_ignored", acc_read_in, 32'h5555_AAAA);
    wr(32'h4000_0000);
    chk("idle_status", acc_read_in, 32'h0);

`ifdef VX_ACC_TIMEOUT_EN
    launch(32'h0000_0007);
    tick();
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 32'd8);
    chk("to_status", acc_read_in, 32'h4);
    wr(32'h8000_0000);
    chk("to_result", acc_read_in, 32'h5555_AAAA);
    wr(32'h4000_0000);
`endif

    // Async reset during WAIT
    launch(32'h0000_0009);
    tick();
    chk("pre_rst_wait", {31'b0, rsp_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("arst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_read", acc_read_in, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    wr(32'h8000_0000);
    chk("arst_result", acc_read_in, 32'h0);

    chk("cmdq_drained", cmd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_acc_csr_bridge.md
VX_ACC_CSR_BRIDGE -- requirements
Module: VX_acc_csr_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: WAIT-state cycles before a response timeout (used only with VX_ACC_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port acc_write_en, input, 1: command-word write strobe from the CSR unit, one pulse per write.
REQ-005 SHALL have port acc_write_out, input, 32: command word; [31:30] op, [29:0] payload.
REQ-006 SHALL have port acc_read_in, output, 32: readback word to the CSR unit.
REQ-007 SHALL have ports cmd_valid (output, 1), cmd_ready (input, 1), cmd_data (output, 32): accelerator command handshake.
REQ-008 SHALL have ports rsp_valid (input, 1), rsp_ready (output, 1), rsp_data (input, 32): accelerator response handshake.
REQ-009 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-010 SHALL decode op as: 00 LAUNCH, 01 SEL_STATUS, 10 SEL_RESULT, 11 CLEAR; only when acc_write_en=1.
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-012 IDLE + LAUNCH SHALL go to ISSUE next cycle, register cmd_data={2'b00,payload}, and clear done and timeout_err.
REQ-013 ISSUE SHALL drive cmd_valid=1 with stable cmd_data; it SHALL go to WAIT in the cycle after cmd_valid&&cmd_ready.
REQ-014 WAIT SHALL drive rsp_ready=1; on rsp_valid it SHALL latch rsp_data into result, set done, and return to IDLE next cycle.
REQ-015 rsp_ready SHALL be 0 outside WAIT; rsp_valid outside WAIT SHALL have no effect.
REQ-016 LAUNCH while not IDLE SHALL be ignored and SHALL set sticky status bit dropped.
REQ-017 CLEAR SHALL zero done, timeout_err and dropped, and SHALL NOT change state, result or sel.
REQ-018 CLEAR in the same cycle as a WAIT response handshake SHALL still leave done=1 (response wins).
REQ-019 SEL_STATUS/SEL_RESULT SHALL set the 1-bit sel register to 0/1 in any state.
REQ-020 acc_read_in SHALL be combinational from registers: sel=0 gives {28'b0, dropped, timeout_err, done, busy}; sel=1 gives result.
REQ-021 Latency: a LAUNCH write in cycle N SHALL give cmd_valid=1 in cycle N+1; the response handshake in cycle M SHALL give done=1 and busy=0 in M+1.
REQ-022 Only one command SHALL be outstanding at a time; no queueing.

Reset
REQ-023 reset SHALL asynchronously force state=IDLE, cmd_valid=0, rsp_ready=0, busy=0, cmd_data=0, result=0, sel=0, done=0, timeout_err=0, dropped=0, timeout counter=0.
REQ-024 Reset asserted mid-ISSUE or mid-WAIT SHALL drop cmd_valid/rsp_ready in that cycle, without waiting for a clock edge, and abandon the command.

Configuration
REQ-025 With macro VX_ACC_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle without a response.
REQ-026 With VX_ACC_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 with no response SHALL set timeout_err and return to IDLE next cycle; result stays unchanged and done stays 0.
REQ-027 A response in the same cycle as expiry SHALL be accepted normally, with no error.
REQ-028 Without VX_ACC_TIMEOUT_EN, there SHALL be no counter, WAIT SHALL last indefinitely, and timeout_err SHALL read constant 0.

Verification
REQ-029 Reset, then write 0x0000_0005 with cmd_ready=1 -> cmd_valid=1 for 1 cycle with cmd_data=0x0000_0005; then rsp_valid with rsp_data=0xDEAD_BEEF -> status reads 0x2; after write 0x8000_0000, acc_read_in=0xDEAD_BEEF.
REQ-030 Hold cmd_ready=0 for 5 cycles after LAUNCH -> cmd_valid and cmd_data stay stable, busy=1, and status reads 0x1.
REQ-031 LAUNCH 0x1, then LAUNCH 0x2 during WAIT -> cmd_data never shows 0x2, and status reads 0x9 while busy.
REQ-032 CLEAR (0xC000_0000) coinciding with the response handshake -> status reads 0x2 the next cycle.
REQ-033 With VX_ACC_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> busy falls after 8 WAIT cycles, status=0x4, result unchanged.
REQ-034 Assert reset during WAIT -> cmd_valid, rsp_ready and busy go 0 in that cycle, and acc_read_in=0.
